// File: rtl/ram_bist.sv
// ram_bist: fill / word / byte-lane self-test for byte-writable DFFRAM macros.
// Expected read data is derived from address, phase and lane; no shadow memory.
module ram_bist #(
  parameter int WORDS  = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int A_W    = $clog2(WORDS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [1:0]          FAIL_PHASE,
  output logic [A_W-1:0]      FAIL_ADDR,
  output logic [DATA_W-1:0]   FAIL_DATA,
  output logic                EN,
  output logic [DATA_W/8-1:0] WE,
  output logic [A_W-1:0]      A,
  output logic [DATA_W-1:0]   Di,
  input  logic [DATA_W-1:0]   Do
);
  localparam int BYTES = DATA_W / 8;
  localparam int L_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BYTES-1:0] LANE0 = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT, S_CMP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [A_W-1:0]    addr_q, addr_d;
  logic [L_W-1:0]    lane_q, lane_d;
  logic              pass_q, pass_d;
  logic [1:0]        fph_q, fph_d;
  logic [A_W-1:0]    fadr_q, fadr_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;
  logic [DATA_W-1:0] pat, exp_w;
  logic              last_a, last_k;

  assign last_a = (addr_q == A_W'(WORDS - 1));
  assign last_k = (lane_q == L_W'(BYTES - 1));

  always_comb begin
    pat = '0;
    for (int k = 0; k < BYTES; k++)
      pat[8*k +: 8] = 8'(addr_q) + 8'(k);
    exp_w = pat;
    case (phase_q)
      2'd2: begin
        for (int k = 0; k < BYTES; k++)
          if (k <= int'(lane_q))
            exp_w[8*k +: 8] = ~pat[8*k +: 8];
      end
      2'd3:    exp_w = ~pat;
      default: exp_w = pat;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    pass_d  = pass_q;
    fph_d   = fph_q;
    fadr_d  = fadr_q;
    fdat_d  = fdat_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_WRITE;
          phase_d = 2'd0;
          addr_d  = '0;
          lane_d  = '0;
          pass_d  = 1'b0;
          fph_d   = '0;
          fadr_d  = '0;
          fdat_d  = '0;
        end
      end
      S_WRITE: begin
        if (phase_q == 2'd0) begin
          addr_d = addr_q + A_W'(1);
          if (last_a) begin
            phase_d = 2'd1;
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: state_d = (RD_LAT == 2) ? S_WAIT : S_CMP;
      S_WAIT: state_d = S_CMP;
      S_CMP: begin
        if (Do != exp_w) begin
          // first mismatch ends the run; nothing more touches the RAM
          state_d = S_DONE;
          pass_d  = 1'b0;
          fph_d   = phase_q;
          fadr_d  = addr_q;
          fdat_d  = Do;
        end else begin
          case (phase_q)
            2'd1: begin
              addr_d  = addr_q + A_W'(1);
              state_d = S_READ;
              if (last_a) begin
                phase_d = 2'd2;
                lane_d  = '0;
                state_d = S_WRITE;
              end
            end
            2'd2: begin
              state_d = S_WRITE;
              if (!last_k) begin
                lane_d = lane_q + L_W'(1);
              end else begin
                lane_d = '0;
                addr_d = addr_q + A_W'(1);
                if (last_a) begin
                  phase_d = 2'd3;
                  state_d = S_READ;
                end
              end
            end
            2'd3: begin
              addr_d  = addr_q + A_W'(1);
              state_d = S_READ;
              if (last_a) begin
                state_d = S_DONE;
                pass_d  = 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      pass_q  <= 1'b0;
      fph_q   <= '0;
      fadr_q  <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      pass_q  <= pass_d;
      fph_q   <= fph_d;
      fadr_q  <= fadr_d;
      fdat_q  <= fdat_d;
    end
  end

  always_comb begin
    EN = 1'b0;
    WE = '0;
    A  = '0;
    Di = '0;
    unique case (1'b1)
      state_q == S_WRITE: begin
        EN = 1'b1;
        A  = addr_q;
        if (phase_q == 2'd0) begin
          WE = '1;
          Di = pat;
        end else begin
          WE = LANE0 << lane_q;
          Di = ~pat;
        end
      end
      state_q == S_READ: begin
        EN = 1'b1;
        A  = addr_q;
      end
      default: ;
    endcase
  end

  assign BUSY       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign DONE       = (state_q == S_DONE);
  assign PASS       = pass_q;
  assign FAIL_PHASE = fph_q;
  assign FAIL_ADDR  = fadr_q;
  assign FAIL_DATA  = fdat_q;

endmodule
